// File: rtl/ex_stage_if.sv
// ex_stage_if: bundle of the signals the execute stage exchanges with the rest
// of the pipeline.
//   stall           : per-stage stop vector (bit2 = EX input reg, bit3 = MEM input reg)
//   id_to_ex_bus    : decoded instruction from ID
//   ex_to_mem_bus   : result bus to MEM, also the EX->ID forwarding source
//   data_sram_*     : data SRAM request (enable, byte write enables, address, store data)
//   ex_load_pending : EX holds a register-writing load
//   ex_load_waddr   : destination register of that load
// Modports: slave = execute stage view, master = pipeline/environment view.
interface ex_stage_if #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int STALL_WD     = 6
);
  logic [STALL_WD-1:0]     stall;
  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic                    data_sram_en;
  logic [3:0]              data_sram_wen;
  logic [31:0]             data_sram_addr;
  logic [31:0]             data_sram_wdata;
  logic                    ex_load_pending;
  logic [4:0]              ex_load_waddr;

  modport slave (
    input  stall, id_to_ex_bus,
    output ex_to_mem_bus, data_sram_en, data_sram_wen, data_sram_addr,
           data_sram_wdata, ex_load_pending, ex_load_waddr
  );

  modport master (
    output stall, id_to_ex_bus,
    input  ex_to_mem_bus, data_sram_en, data_sram_wen, data_sram_addr,
           data_sram_wdata, ex_load_pending, ex_load_waddr
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
// Captures id_to_ex_bus into an input register under stall control, selects
// the ALU operands, evaluates the one-hot 12-op ALU and drives the data SRAM
// request, ex_to_mem_bus and the load-use hazard export back to ID.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset
//   ex_if : ex_stage_if.slave (stall, id_to_ex_bus in; ex_to_mem_bus,
//           data_sram_*, ex_load_pending, ex_load_waddr out)
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int STALL_WD     = 6
) (
  input  logic        clk,
  input  logic        rst,
  ex_stage_if.slave   ex_if
);

  logic [ID_TO_EX_WD-1:0] id_to_ex_bus_r;

  // Decoded fields of the input register
  logic [31:0] pc_s;
  logic [31:0] inst_s;
  logic [11:0] alu_op_s;
  logic [2:0]  sel_src1_s;
  logic [3:0]  sel_src2_s;
  logic        data_ram_en_s;
  logic [3:0]  data_ram_wen_s;
  logic        rf_we_s;
  logic [4:0]  rf_waddr_s;
  logic        sel_rf_res_s;
  logic [31:0] data1_s;
  logic [31:0] data2_s;

  logic [31:0] src1_s;
  logic [31:0] src2_s;
  logic [31:0] ex_result_s;
  logic        rf_we_out_s;

  // Input register: reset, then bubble (EX stopped while MEM runs), then capture, else hold
  always_ff @(posedge clk) begin
    if (rst) begin
      id_to_ex_bus_r <= {ID_TO_EX_WD{1'b0}};
    end else if (ex_if.stall[2] && !ex_if.stall[3]) begin
      id_to_ex_bus_r <= {ID_TO_EX_WD{1'b0}};
    end else if (!ex_if.stall[2]) begin
      id_to_ex_bus_r <= ex_if.id_to_ex_bus;
    end else begin
      id_to_ex_bus_r <= id_to_ex_bus_r;
    end
  end

  assign {pc_s, inst_s, alu_op_s, sel_src1_s, sel_src2_s, data_ram_en_s,
          data_ram_wen_s, rf_we_s, rf_waddr_s, sel_rf_res_s, data1_s,
          data2_s} = id_to_ex_bus_r;

  // Operand selects are one-hot; AND-OR form yields 0 when no select bit is set.
  assign src1_s = ({32{sel_src1_s[0]}} & data1_s)
                | ({32{sel_src1_s[1]}} & pc_s)
                | ({32{sel_src1_s[2]}} & {27'd0, inst_s[10:6]});

  assign src2_s = ({32{sel_src2_s[0]}} & data2_s)
                | ({32{sel_src2_s[1]}} & {{16{inst_s[15]}}, inst_s[15:0]})
                | ({32{sel_src2_s[2]}} & 32'd8)
                | ({32{sel_src2_s[3]}} & {16'd0, inst_s[15:0]});

  // One-hot ALU: each op result gated by its alu_op bit, then ORed together
  always_comb begin
    logic [31:0] add_s;
    logic [31:0] sub_s;
    logic [31:0] slt_s;
    logic [31:0] sltu_s;
    logic [31:0] sll_s;
    logic [31:0] srl_s;
    logic [31:0] sra_s;
    logic [31:0] lui_s;
    add_s  = src1_s + src2_s;
    sub_s  = src1_s - src2_s;
    slt_s  = {31'd0, ($signed(src1_s) < $signed(src2_s))};
    sltu_s = {31'd0, (src1_s < src2_s)};
    sll_s  = src2_s << src1_s[4:0];
    srl_s  = src2_s >> src1_s[4:0];
    sra_s  = $unsigned($signed(src2_s) >>> src1_s[4:0]);
    lui_s  = {src2_s[15:0], 16'd0};
    ex_result_s = ({32{alu_op_s[11]}} & add_s)
                | ({32{alu_op_s[10]}} & sub_s)
                | ({32{alu_op_s[9]}}  & slt_s)
                | ({32{alu_op_s[8]}}  & sltu_s)
                | ({32{alu_op_s[7]}}  & (src1_s & src2_s))
                | ({32{alu_op_s[6]}}  & ~(src1_s | src2_s))
                | ({32{alu_op_s[5]}}  & (src1_s | src2_s))
                | ({32{alu_op_s[4]}}  & (src1_s ^ src2_s))
                | ({32{alu_op_s[3]}}  & sll_s)
                | ({32{alu_op_s[2]}}  & srl_s)
                | ({32{alu_op_s[1]}}  & sra_s)
                | ({32{alu_op_s[0]}}  & lui_s);
  end

  // $0 is never written, so it must never look like a forwarding source either.
  assign rf_we_out_s = rf_we_s & (rf_waddr_s != 5'd0);

  // rf_we/rf_waddr/ex_result occupy [37], [36:32], [31:0]; ID forwarding relies on this.
  assign ex_if.ex_to_mem_bus = {pc_s, data_ram_en_s, data_ram_wen_s,
                                sel_rf_res_s, rf_we_out_s, rf_waddr_s,
                                ex_result_s};

  assign ex_if.data_sram_en    = data_ram_en_s;
  assign ex_if.data_sram_wen   = data_ram_en_s ? data_ram_wen_s : 4'd0;
  assign ex_if.data_sram_addr  = ex_result_s;
  assign ex_if.data_sram_wdata = data2_s;

  assign ex_if.ex_load_pending = sel_rf_res_s & rf_we_out_s;
  assign ex_if.ex_load_waddr   = rf_waddr_s;

  // Instruction bits and stall bits this stage does not look at
  logic unused_bits_s;
  assign unused_bits_s = ^{inst_s[31:16], ex_if.stall[STALL_WD-1:4],
                           ex_if.stall[1:0]};

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage.
module tb_ex_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ex_stage_if #(.ID_TO_EX_WD(159), .EX_TO_MEM_WD(76), .STALL_WD(6)) ex_if ();

  ex_stage #(.ID_TO_EX_WD(159), .EX_TO_MEM_WD(76), .STALL_WD(6)) dut (
    .clk  (clk),
    .rst  (rst),
    .ex_if(ex_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [158:0] mk_bus(
    input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] alu_op,
    input logic [2:0] s1, input logic [3:0] s2, input logic en,
    input logic [3:0] wen, input logic we, input logic [4:0] waddr,
    input logic selres, input logic [31:0] d1, input logic [31:0] d2);
    return {pc, inst, alu_op, s1, s2, en, wen, we, waddr, selres, d1, d2};
  endfunction

  // drive one vector, let it be captured, sample 1 time unit after the edge
  task automatic step(input logic [158:0] bus, input logic [5:0] stl);
    ex_if.id_to_ex_bus = bus;
    ex_if.stall        = stl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(mk_bus(32'hBFC00000, 32'hFFFFFFFF, 12'h800, 3'b001, 4'b0001, 1'b1,
                4'hF, 1'b1, 5'd9, 1'b1, 32'h11111111, 32'h22222222), 6'b000000);
    checks++;
    if (ex_if.ex_to_mem_bus !== 76'd0) begin
      errors++;
      $display("FAIL reset_bus: got %h expected 0", ex_if.ex_to_mem_bus);
    end
    checks++;
    if ({ex_if.data_sram_en, ex_if.data_sram_wen, ex_if.data_sram_addr,
         ex_if.data_sram_wdata, ex_if.ex_load_pending, ex_if.ex_load_waddr} !== 75'd0) begin
      errors++;
      $display("FAIL reset_sram: en=%b wen=%b addr=%h wdata=%h lp=%b lw=%0d expected all 0",
               ex_if.data_sram_en, ex_if.data_sram_wen, ex_if.data_sram_addr,
               ex_if.data_sram_wdata, ex_if.ex_load_pending, ex_if.ex_load_waddr);
    end
    rst = 1'b0;
  endtask

  task automatic test_addu();
    step(mk_bus(32'hBFC00004, 32'h0, 12'h800, 3'b001, 4'b0001, 1'b0, 4'h0,
                1'b1, 5'd8, 1'b0, 32'h7FFFFFFF, 32'h00000001), 6'b000000);
    checks++;
    if (ex_if.ex_to_mem_bus[31:0] !== 32'h80000000) begin
      errors++;
      $display("FAIL addu_result: got %h expected 80000000", ex_if.ex_to_mem_bus[31:0]);
    end
    checks++;
    if (ex_if.ex_to_mem_bus[37:32] !== {1'b1, 5'd8}) begin
      errors++;
      $display("FAIL addu_wb: got we/waddr %b expected 101000", ex_if.ex_to_mem_bus[37:32]);
    end
    checks++;
    if (ex_if.ex_to_mem_bus[75:44] !== 32'hBFC00004 || ex_if.data_sram_en !== 1'b0) begin
      errors++;
      $display("FAIL addu_pc: got pc %h en %b expected BFC00004 0",
               ex_if.ex_to_mem_bus[75:44], ex_if.data_sram_en);
    end
  endtask

  task automatic test_jal();
    step(mk_bus(32'hBFC00010, 32'h0C000000, 12'h800, 3'b010, 4'b0100, 1'b0,
                4'h0, 1'b1, 5'd31, 1'b0, 32'h12345678, 32'h9ABCDEF0), 6'b000000);
    checks++;
    if (ex_if.ex_to_mem_bus[31:0] !== 32'hBFC00018) begin
      errors++;
      $display("FAIL jal_result: got %h expected BFC00018", ex_if.ex_to_mem_bus[31:0]);
    end
    checks++;
    if (ex_if.ex_to_mem_bus[37:32] !== {1'b1, 5'd31}) begin
      errors++;
      $display("FAIL jal_wb: got %b expected 111111", ex_if.ex_to_mem_bus[37:32]);
    end
  endtask

  task automatic test_shift_lui();
    // sa field inst[10:6] = 4
    step(mk_bus(32'h0, 32'h00000100, 12'h002, 3'b100, 4'b0001, 1'b0, 4'h0,
                1'b1, 5'd3, 1'b0, 32'h0, 32'hF0000000), 6'b000000);
    checks++;
    if (ex_if.ex_to_mem_bus[31:0] !== 32'hFF000000) begin
      errors++;
      $display("FAIL sra_result: got %h expected FF000000", ex_if.ex_to_mem_bus[31:0]);
    end
    step(mk_bus(32'h0, 32'h00000100, 12'h004, 3'b100, 4'b0001, 1'b0, 4'h0,
                1'b1, 5'd3, 1'b0, 32'h0, 32'hF0000000), 6'b000000);
    checks++;
    if (ex_if.ex_to_mem_bus[31:0] !== 32'h0F000000) begin
      errors++;
      $display("FAIL srl_result: got %h expected 0F000000", ex_if.ex_to_mem_bus[31:0]);
    end
    step(mk_bus(32'h0, 32'h00000100, 12'h008, 3'b100, 4'b0001, 1'b0, 4'h0,
                1'b1, 5'd3, 1'b0, 32'h0, 32'h0000000F), 6'b000000);
    checks++;
    if (ex_if.ex_to_mem_bus[31:0] !== 32'h000000F0) begin
      errors++;
      $display("FAIL sll_result: got %h expected 000000F0", ex_if.ex_to_mem_bus[31:0]);
    end
    step(mk_bus(32'h0, 32'h3C011234, 12'h001, 3'b000, 4'b1000, 1'b0, 4'h0,
                1'b1, 5'd1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF), 6'b000000);
    checks++;
    if (ex_if.ex_to_mem_bus[31:0] !== 32'h12340000) begin
      errors++;
      $display("FAIL lui_result: got %h expected 12340000", ex_if.ex_to_mem_bus[31:0]);
    end
  endtask

  task automatic test_slt_zero();
    step(mk_bus(32'h0, 32'h0, 12'h100, 3'b001, 4'b0001, 1'b0, 4'h0,
                1'b1, 5'd4, 1'b0, 32'h00000001, 32'hFFFFFFFF), 6'b000000);
    checks++;
    if (ex_if.ex_to_mem_bus[31:0] !== 32'h00000001) begin
      errors++;
      $display("FAIL sltu_result: got %h expected 00000001", ex_if.ex_to_mem_bus[31:0]);
    end
    step(mk_bus(32'h0, 32'h0, 12'h200, 3'b001, 4'b0001, 1'b0, 4'h0,
                1'b1, 5'd0, 1'b0, 32'h00000001, 32'hFFFFFFFF), 6'b000000);
    checks++;
    if (ex_if.ex_to_mem_bus[31:0] !== 32'h00000000) begin
      errors++;
      $display("FAIL slt_result: got %h expected 00000000", ex_if.ex_to_mem_bus[31:0]);
    end
    checks++;
    if (ex_if.ex_to_mem_bus[37] !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg_we: got %b expected 0", ex_if.ex_to_mem_bus[37]);
    end
  endtask

  task automatic test_load();
    // lw $5, 4($x): address 0x1004, register-writing load
    step(mk_bus(32'h0, 32'h00000004, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0,
                1'b1, 5'd5, 1'b1, 32'h00001000, 32'h0), 6'b000000);
    checks++;
    if (ex_if.ex_load_pending !== 1'b1 || ex_if.ex_load_waddr !== 5'd5) begin
      errors++;
      $display("FAIL load_pending: got %b/%0d expected 1/5",
               ex_if.ex_load_pending, ex_if.ex_load_waddr);
    end
    checks++;
    if (ex_if.data_sram_addr !== 32'h00001004 || ex_if.data_sram_en !== 1'b1 ||
        ex_if.data_sram_wen !== 4'h0) begin
      errors++;
      $display("FAIL load_sram: got addr %h en %b wen %b expected 00001004 1 0000",
               ex_if.data_sram_addr, ex_if.data_sram_en, ex_if.data_sram_wen);
    end
    // write enables are ignored without data_ram_en; load into $0 is not pending
    step(mk_bus(32'h0, 32'h00000004, 12'h800, 3'b001, 4'b0010, 1'b0, 4'hF,
                1'b1, 5'd0, 1'b1, 32'h00001000, 32'h0), 6'b000000);
    checks++;
    if (ex_if.data_sram_wen !== 4'h0 || ex_if.ex_load_pending !== 1'b0) begin
      errors++;
      $display("FAIL wen_gate: got wen %b lp %b expected 0000 0",
               ex_if.data_sram_wen, ex_if.ex_load_pending);
    end
  endtask

  task automatic test_sw_stall();
    logic [75:0] held;
    // sw: addr = 0x1000 + signext(0xFFFC) = 0x0FFC
    step(mk_bus(32'hBFC00020, 32'hAC00FFFC, 12'h800, 3'b001, 4'b0010, 1'b1,
                4'hF, 1'b0, 5'd0, 1'b0, 32'h00001000, 32'hDEADBEEF), 6'b000000);
    held = {32'hBFC00020, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h00000FFC};
    checks++;
    if (ex_if.data_sram_en !== 1'b1 || ex_if.data_sram_wen !== 4'hF ||
        ex_if.data_sram_addr !== 32'h00000FFC || ex_if.data_sram_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_sram: got en %b wen %b addr %h wdata %h expected 1 1111 00000FFC DEADBEEF",
               ex_if.data_sram_en, ex_if.data_sram_wen, ex_if.data_sram_addr,
               ex_if.data_sram_wdata);
    end
    checks++;
    if (ex_if.ex_to_mem_bus !== held) begin
      errors++;
      $display("FAIL sw_bus: got %h expected %h", ex_if.ex_to_mem_bus, held);
    end
    for (int i = 0; i < 3; i++) begin
      step(mk_bus(32'h11111111, 32'h0, 12'h400, 3'b001, 4'b0001, 1'b1, 4'h3,
                  1'b1, 5'd7, 1'b0, 32'h5, 32'h6), 6'b001100);
      checks++;
      if (ex_if.ex_to_mem_bus !== held || ex_if.data_sram_wdata !== 32'hDEADBEEF ||
          ex_if.data_sram_wen !== 4'hF) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got bus %h wdata %h wen %b expected %h DEADBEEF 1111",
                 i, ex_if.ex_to_mem_bus, ex_if.data_sram_wdata, ex_if.data_sram_wen, held);
      end
    end
    step(mk_bus(32'h11111111, 32'h0, 12'h400, 3'b001, 4'b0001, 1'b1, 4'h3,
                1'b1, 5'd7, 1'b0, 32'h5, 32'h6), 6'b000100);
    checks++;
    if (ex_if.ex_to_mem_bus !== 76'd0 || ex_if.data_sram_en !== 1'b0 ||
        ex_if.data_sram_wen !== 4'h0 || ex_if.data_sram_wdata !== 32'h0) begin
      errors++;
      $display("FAIL bubble: got bus %h en %b wen %b wdata %h expected all 0",
               ex_if.ex_to_mem_bus, ex_if.data_sram_en, ex_if.data_sram_wen,
               ex_if.data_sram_wdata);
    end
  endtask

  task automatic test_back_to_back();
    // sub then nor on consecutive cycles, no stall
    step(mk_bus(32'h0, 32'h0, 12'h400, 3'b001, 4'b0001, 1'b0, 4'h0,
                1'b1, 5'd2, 1'b0, 32'h00000005, 32'h00000007), 6'b000000);
    checks++;
    if (ex_if.ex_to_mem_bus[31:0] !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL b2b_sub: got %h expected FFFFFFFE", ex_if.ex_to_mem_bus[31:0]);
    end
    step(mk_bus(32'h0, 32'h0, 12'h040, 3'b001, 4'b0001, 1'b0, 4'h0,
                1'b1, 5'd2, 1'b0, 32'h0000F0F0, 32'h00000F0F), 6'b000000);
    checks++;
    if (ex_if.ex_to_mem_bus[31:0] !== 32'hFFFF0000) begin
      errors++;
      $display("FAIL b2b_nor: got %h expected FFFF0000", ex_if.ex_to_mem_bus[31:0]);
    end
    // and / or / xor on the same operands
    step(mk_bus(32'h0, 32'h0, 12'h080, 3'b001, 4'b0001, 1'b0, 4'h0,
                1'b1, 5'd2, 1'b0, 32'h0000FF0F, 32'h00000FF0), 6'b000000);
    checks++;
    if (ex_if.ex_to_mem_bus[31:0] !== 32'h00000F00) begin
      errors++;
      $display("FAIL b2b_and: got %h expected 00000F00", ex_if.ex_to_mem_bus[31:0]);
    end
    step(mk_bus(32'h0, 32'h0, 12'h020, 3'b001, 4'b0001, 1'b0, 4'h0,
                1'b1, 5'd2, 1'b0, 32'h0000FF0F, 32'h00000FF0), 6'b000000);
    checks++;
    if (ex_if.ex_to_mem_bus[31:0] !== 32'h0000FFFF) begin
      errors++;
      $display("FAIL b2b_or: got %h expected 0000FFFF", ex_if.ex_to_mem_bus[31:0]);
    end
    step(mk_bus(32'h0, 32'h0, 12'h010, 3'b001, 4'b0001, 1'b0, 4'h0,
                1'b1, 5'd2, 1'b0, 32'h0000FF0F, 32'h00000FF0), 6'b000000);
    checks++;
    if (ex_if.ex_to_mem_bus[31:0] !== 32'h0000F0FF) begin
      errors++;
      $display("FAIL b2b_xor: got %h expected 0000F0FF", ex_if.ex_to_mem_bus[31:0]);
    end
  endtask

  task automatic test_reset_mid_stall();
    step(mk_bus(32'h0, 32'h0, 12'h800, 3'b001, 4'b0001, 1'b0, 4'h0,
                1'b1, 5'd6, 1'b0, 32'h00000010, 32'h00000020), 6'b000000);
    rst = 1'b1;
    step(mk_bus(32'h0, 32'h0, 12'h800, 3'b001, 4'b0001, 1'b0, 4'h0,
                1'b1, 5'd6, 1'b0, 32'h00000010, 32'h00000020), 6'b001100);
    checks++;
    if (ex_if.ex_to_mem_bus !== 76'd0) begin
      errors++;
      $display("FAIL reset_in_stall: got %h expected 0", ex_if.ex_to_mem_bus);
    end
    rst = 1'b0;
    step(mk_bus(32'h0, 32'h0, 12'h800, 3'b001, 4'b0001, 1'b0, 4'h0,
                1'b1, 5'd6, 1'b0, 32'h00000100, 32'h00000023), 6'b000000);
    checks++;
    if (ex_if.ex_to_mem_bus[37:0] !== {1'b1, 5'd6, 32'h00000123}) begin
      errors++;
      $display("FAIL after_reset_capture: got %h expected %h",
               ex_if.ex_to_mem_bus[37:0], {1'b1, 5'd6, 32'h00000123});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ex_if.stall = 6'd0;
    ex_if.id_to_ex_bus = 159'd0;
    test_reset();
    test_addu();
    test_jal();
    test_shift_lui();
    test_slt_zero();
    test_load();
    test_sw_stall();
    test_back_to_back();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
